// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT twiddle-stage complex multiplier.
// sat_round works on a wide signed container so one function serves any parameterisation.
package fft_pkg;

    localparam int CMUL_LATENCY = 3;
    localparam int SAT_MAX_W    = 128;

    typedef struct packed {
        logic [7:0] shift;
        logic [7:0] out_width;
    } cmul_cfg_t;

    // Round half toward +inf, then clamp to a signed out_width range.
    // The returned value is sign-extended to SAT_MAX_W; o_sat flags a clamp.
    function automatic logic signed [SAT_MAX_W-1:0] sat_round(
        input  logic signed [SAT_MAX_W-1:0] sum,
        input  int                          shift,
        input  int                          out_width,
        output logic                        o_sat
    );
        logic signed [SAT_MAX_W-1:0] rounded;
        logic signed [SAT_MAX_W-1:0] max_v;
        logic signed [SAT_MAX_W-1:0] min_v;
        if (shift > 0) begin
            rounded = (sum + $signed(SAT_MAX_W'(1) << (shift - 1))) >>> shift;
        end else begin
            rounded = sum;
        end
        max_v = $signed((SAT_MAX_W'(1) << (out_width - 1)) - SAT_MAX_W'(1));
        min_v = -$signed(SAT_MAX_W'(1) << (out_width - 1));
        o_sat = 1'b0;
        if (rounded > max_v) begin
            rounded = max_v;
            o_sat   = 1'b1;
        end else if (rounded < min_v) begin
            rounded = min_v;
            o_sat   = 1'b1;
        end
        return rounded;
    endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// Combinational round-and-saturate for one component of the complex product.
module cmul_round_sat
    import fft_pkg::*;
#(
    parameter  int        IN_W  = 38,
    parameter  cmul_cfg_t CFG   = '{shift: 8'd15, out_width: 8'd22},
    localparam int        OUT_W = int'(CFG.out_width)
) (
    input  logic signed [IN_W-1:0]  i_sum,
    output logic signed [OUT_W-1:0] o_val,
    output logic                    o_sat
);

    logic signed [SAT_MAX_W-1:0] w_sum_ext;
    logic                        w_sat;

    always_comb begin
        w_sum_ext = {{(SAT_MAX_W-IN_W){i_sum[IN_W-1]}}, i_sum};
        w_sat     = 1'b0;
        // After clamping, the upper bits are pure sign extension, so truncation is exact.
        o_val     = OUT_W'(sat_round(w_sum_ext, int'(CFG.shift), OUT_W, w_sat));
        o_sat     = w_sat;
    end

endmodule

// File: rtl/complex_mul_stream.sv
// Three-stage streaming signed complex multiplier (a * b or a * conj(b)) with rounding,
// saturation, sticky saturation flag and tag pass-through under valid/ready flow control.
module complex_mul_stream
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 21,
    parameter int TWID_WIDTH = 16,
    parameter int OUT_WIDTH  = 22,
    parameter int SHIFT      = 15,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] a_r,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [TWID_WIDTH-1:0] b_r,
    input  logic signed [TWID_WIDTH-1:0] b_i,
    input  logic                         in_conj,
    input  logic [TAG_WIDTH-1:0]         in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  c_r,
    output logic signed [OUT_WIDTH-1:0]  c_i,
    output logic [TAG_WIDTH-1:0]         out_tag,
    output logic                         out_sat,
    output logic                         sat_sticky
);

    localparam int        PW  = DATA_WIDTH + TWID_WIDTH;
    localparam int        SW  = PW + 1;
    localparam cmul_cfg_t CFG = '{shift: 8'(SHIFT), out_width: 8'(OUT_WIDTH)};

    // Handshake: valid/ready. A transfer happens on a rising edge where valid and ready are
    // both high. The whole pipe advances together (w_adv); in_ready equals w_adv and never
    // looks at in_valid, and outputs stay frozen while out_valid is high and out_ready low.
    logic w_adv;

    logic                  r_v1;
    logic                  r_v2;
    logic signed [PW-1:0]  r_p_rr;
    logic signed [PW-1:0]  r_p_ii;
    logic signed [PW-1:0]  r_p_ri;
    logic signed [PW-1:0]  r_p_ir;
    logic                  r_conj1;
    logic [TAG_WIDTH-1:0]  r_tag1;
    logic [TAG_WIDTH-1:0]  r_tag2;
    logic signed [SW-1:0]  r_sum_r;
    logic signed [SW-1:0]  r_sum_i;

    logic signed [SW-1:0]        w_rr;
    logic signed [SW-1:0]        w_ii;
    logic signed [SW-1:0]        w_ri;
    logic signed [SW-1:0]        w_ir;
    logic signed [OUT_WIDTH-1:0] w_c_r;
    logic signed [OUT_WIDTH-1:0] w_c_i;
    logic                        w_sat_r;
    logic                        w_sat_i;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // One guard bit lets the -2^(TWID_WIDTH-1) twiddle sum without wrapping.
    assign w_rr = {r_p_rr[PW-1], r_p_rr};
    assign w_ii = {r_p_ii[PW-1], r_p_ii};
    assign w_ri = {r_p_ri[PW-1], r_p_ri};
    assign w_ir = {r_p_ir[PW-1], r_p_ir};

    // Datapath registers carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_p_rr  <= PW'(a_r) * PW'(b_r);
            r_p_ii  <= PW'(a_i) * PW'(b_i);
            r_p_ri  <= PW'(a_r) * PW'(b_i);
            r_p_ir  <= PW'(a_i) * PW'(b_r);
            r_conj1 <= in_conj;
            r_tag1  <= in_tag;
            r_sum_r <= r_conj1 ? (w_rr + w_ii) : (w_rr - w_ii);
            r_sum_i <= r_conj1 ? (w_ir - w_ri) : (w_ri + w_ir);
            r_tag2  <= r_tag1;
        end
    end

    cmul_round_sat #(
        .IN_W (SW),
        .CFG  (CFG)
    ) u_rs_r (
        .i_sum (r_sum_r),
        .o_val (w_c_r),
        .o_sat (w_sat_r)
    );

    cmul_round_sat #(
        .IN_W (SW),
        .CFG  (CFG)
    ) u_rs_i (
        .i_sum (r_sum_i),
        .o_val (w_c_i),
        .o_sat (w_sat_i)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            out_valid  <= 1'b0;
            c_r        <= '0;
            c_i        <= '0;
            out_tag    <= '0;
            out_sat    <= 1'b0;
            sat_sticky <= 1'b0;
        end else begin
            if (out_valid && out_ready && out_sat) begin
                sat_sticky <= 1'b1;
            end
            if (w_adv) begin
                r_v1      <= in_valid;
                r_v2      <= r_v1;
                out_valid <= r_v2;
                c_r       <= w_c_r;
                c_i       <= w_c_i;
                out_tag   <= r_tag2;
                out_sat   <= w_sat_r || w_sat_i;
            end
        end
    end

endmodule

// File: tb/tb_complex_mul_stream.sv
// Bench for complex_mul_stream: directed cases, randomized backpressure streams and
// mid-flight reset, scored against an integer-arithmetic reference model.
module tb_complex_mul_stream;
    import fft_pkg::*;

    localparam int DW    = 21;
    localparam int TW    = 16;
    localparam int OW    = 21;
    localparam int SH    = 15;
    localparam int TGW   = 8;
    localparam int EXP_W = 2 * OW + TGW + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [DW-1:0]  a_r;
    logic signed [DW-1:0]  a_i;
    logic signed [TW-1:0]  b_r;
    logic signed [TW-1:0]  b_i;
    logic                  in_conj;
    logic [TGW-1:0]        in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [OW-1:0]  c_r;
    logic signed [OW-1:0]  c_i;
    logic [TGW-1:0]        out_tag;
    logic                  out_sat;
    logic                  sat_sticky;

    int total = 0;
    int bad   = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic             bp_mode = 1'b0;
    logic             mon_en  = 1'b0;
    logic             held_v  = 1'b0;
    logic [EXP_W-1:0] held;

    complex_mul_stream #(
        .DATA_WIDTH (DW),
        .TWID_WIDTH (TW),
        .OUT_WIDTH  (OW),
        .SHIFT      (SH),
        .TAG_WIDTH  (TGW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_r        (a_r),
        .a_i        (a_i),
        .b_r        (b_r),
        .b_i        (b_i),
        .in_conj    (in_conj),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .c_r        (c_r),
        .c_i        (c_i),
        .out_tag    (out_tag),
        .out_sat    (out_sat),
        .sat_sticky (sat_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Floor division after adding half an LSB: round half toward +inf.
    function automatic longint scale(input longint v);
        longint d, q, n;
        if (SH == 0) return v;
        d = longint'(1) << SH;
        n = v + d / 2;
        q = n / d;
        if (n < 0 && q * d != n) q = q - 1;
        return q;
    endfunction

    function automatic logic [EXP_W-1:0] model(input longint ar, input longint ai,
                                               input longint br, input longint bi,
                                               input logic cj, input logic [TGW-1:0] tg);
        longint re, im, hi, lo;
        logic   sat;
        re  = cj ? (ar * br + ai * bi) : (ar * br - ai * bi);
        im  = cj ? (ai * br - ar * bi) : (ar * bi + ai * br);
        re  = scale(re);
        im  = scale(im);
        hi  = (longint'(1) << (OW - 1)) - 1;
        lo  = -(longint'(1) << (OW - 1));
        sat = 1'b0;
        if (re > hi) begin re = hi; sat = 1'b1; end
        if (re < lo) begin re = lo; sat = 1'b1; end
        if (im > hi) begin im = hi; sat = 1'b1; end
        if (im < lo) begin im = lo; sat = 1'b1; end
        return {OW'(re), OW'(im), tg, sat};
    endfunction

    // Output monitor: scoreboard pops, stall stability and in_ready mirroring.
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            held_v = 1'b0;
        end else begin
            check("in_ready_adv", in_ready, !out_valid || out_ready);
            if (held_v) begin
                check("stall_hold", {out_valid, c_r, c_i, out_tag, out_sat}, {1'b1, held});
            end
            if (out_valid && out_ready) begin
                check("queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("result", {c_r, c_i, out_tag, out_sat}, exp_q.pop_front());
                end
            end
            held_v = out_valid && !out_ready;
            held   = {c_r, c_i, out_tag, out_sat};
        end
    end

    task automatic set_ready();
        if (bp_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            set_ready();
        end
    endtask

    task automatic send(input logic signed [DW-1:0] ar, input logic signed [DW-1:0] ai,
                        input logic signed [TW-1:0] br, input logic signed [TW-1:0] bi,
                        input logic cj, input logic [TGW-1:0] tg);
        logic got;
        a_r = ar; a_i = ai; b_r = br; b_i = bi; in_conj = cj; in_tag = tg;
        in_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            if (got) begin
                exp_q.push_back(model(ar, ai, br, bi, cj, tg));
                #1;
                in_valid = 1'b0;
                set_ready();
                return;
            end
            #1;
            set_ready();
        end
        check("send_accept", got, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [TGW-1:0] tg);
        logic signed [DW-1:0] ar, ai;
        logic signed [TW-1:0] br, bi;
        ar = DW'($urandom);
        ai = DW'($urandom);
        br = TW'($urandom);
        bi = TW'($urandom);
        if ($urandom_range(0, 3) == 0) ar = -(DW'(1) << (DW - 1));
        if ($urandom_range(0, 3) == 0) br = -(TW'(1) << (TW - 1));
        send(ar, ai, br, bi, 1'($urandom_range(0, 1)), tg);
    endtask

    task automatic drain();
        for (int n = 0; n < 2000; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
            set_ready();
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic directed(input string name,
                            input logic signed [DW-1:0] ar, input logic signed [DW-1:0] ai,
                            input logic signed [TW-1:0] br, input logic signed [TW-1:0] bi,
                            input logic cj, input logic [TGW-1:0] tg,
                            input longint ecr, input longint eci, input logic esat);
        send(ar, ai, br, bi, cj, tg);
        repeat (CMUL_LATENCY - 2) @(posedge clk);
        #1;
        check({name, "_early"}, out_valid, 0);
        @(posedge clk);
        #1;
        check({name, "_valid"}, out_valid, 1);
        check({name, "_cr"}, c_r, ecr);
        check({name, "_ci"}, c_i, eci);
        check({name, "_tag"}, out_tag, tg);
        check({name, "_sat"}, out_sat, esat);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_r = '0; a_i = '0; b_r = '0; b_i = '0; in_conj = 1'b0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_c_r", c_r, 0);
        check("rst_c_i", c_i, 0);
        check("rst_tag", out_tag, 0);
        check("rst_sat", out_sat, 0);
        check("rst_sticky", sat_sticky, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        directed("basic", 21'sd1000, -21'sd500, 16'sd16384, 16'sd0, 1'b0, 8'h5A, 500, -250, 1'b0);
        directed("rnd_pos", 21'sd3, 21'sd0, 16'sd16384, 16'sd0, 1'b0, 8'h01, 2, 0, 1'b0);
        directed("rnd_neg", -21'sd3, 21'sd0, 16'sd16384, 16'sd0, 1'b0, 8'h02, -1, 0, 1'b0);
        directed("conj1", 21'sd0, 21'sd1000, 16'sd0, 16'sd32767, 1'b1, 8'h03, 1000, 0, 1'b0);
        directed("conj0", 21'sd0, 21'sd1000, 16'sd0, 16'sd32767, 1'b0, 8'h04, -1000, 0, 1'b0);
        idle(2);
        check("sticky_clear", sat_sticky, 0);

        directed("sat", -21'sd1048576, 21'sd1048575, -16'sd32768, -16'sd32768, 1'b0, 8'hC3,
                 1048575, 1, 1'b1);
        @(posedge clk);
        #1;
        check("sticky_set", sat_sticky, 1);
        idle(2);

        bp_mode = 1'b1;
        for (int i = 0; i < 10; i++) send_rand(TGW'(8'h10 + i));
        drain();

        for (int i = 0; i < 60; i++) begin
            idle($urandom_range(0, 2));
            send_rand(TGW'($urandom));
        end
        drain();
        bp_mode = 1'b0;
        out_ready = 1'b1;
        idle(3);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand(TGW'(8'hE0 + i));
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sticky", sat_sticky, 0);
        check("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_emerge", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/complex_mul_stream.md
Name: complex_mul_stream

Overview:
- Streaming, fully pipelined signed complex multiplier for the FFT twiddle stage, with valid/ready flow control on input and output.
- Adds a per-sample conjugate mode, round-half-up right shift, output saturation with a sticky flag, and a sideband tag that passes through aligned with the data.
- Sits between a butterfly output and the next FFT stage. Consumes raw butterfly data plus a twiddle (Q1.(TWID_WIDTH-1)) and produces a scaled, width-reduced product.

Parameters:
DATA_WIDTH, 21, signed width of a_r/a_i
TWID_WIDTH, 16, signed width of b_r/b_i (Q1.15 at default)
OUT_WIDTH, 22, signed width of c_r/c_i after shift and saturation
SHIFT, 15, arithmetic right shift applied to the full-precision sum (0 allowed: no rounding)
TAG_WIDTH, 8, width of sideband tag (minimum 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset; synchronous, active-high
in_valid  in  1  input sample valid
in_ready  out  1  block can accept input this cycle
a_r  in  DATA_WIDTH  data real, signed
a_i  in  DATA_WIDTH  data imag, signed
b_r  in  TWID_WIDTH  twiddle real, signed
b_i  in  TWID_WIDTH  twiddle imag, signed
in_conj  in  1  1: multiply a by conj(b)
in_tag  in  TAG_WIDTH  sideband, returned with the result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
c_r  out  OUT_WIDTH  result real, signed
c_i  out  OUT_WIDTH  result imag, signed
out_tag  out  TAG_WIDTH  tag of this result
out_sat  out  1  this result was saturated (r or i)
sat_sticky  out  1  set on any saturated output transfer; cleared only by rst

Behaviour:
- Reset (rst=1 at a clk edge): all stage valids, out_valid, c_r, c_i, out_tag, out_sat and sat_sticky go to 0. In-flight samples are discarded. in_ready=1 in the cycle after reset.
- Pipeline: three stages, S1 → S2 → S3. S3 drives the outputs directly from registers.
- Global enable: adv = !out_valid || out_ready. in_ready = adv, combinational and independent of in_valid.
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- When adv=1, every stage loads from the previous one: S1 valid ← in_valid. When adv=0, all stages hold.
- Bubbles are not collapsed.
- Latency: exactly 3 cycles from input transfer to out_valid when out_ready is held high. Throughput is 1 sample/clk.
- S1 registers four products, each DATA_WIDTH+TWID_WIDTH bits signed: ar*br, ai*bi, ar*bi, ai*br, plus conj and tag.
- S2 forms the sums at W = DATA_WIDTH+TWID_WIDTH+1 bits:
  - conj=0: c_r = ar*br - ai*bi, c_i = ar*bi + ai*br
  - conj=1: c_r = ar*br + ai*bi, c_i = ai*br - ar*bi
- S3, when SHIFT>0: add 2^(SHIFT-1), then arithmetic shift right by SHIFT (round half toward +inf). When SHIFT=0, pass the sum unchanged.
- S3 saturation: clamp each component to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. out_sat = clamp occurred on either component.
- sat_sticky is set on an output transfer carrying out_sat=1.
- Outputs are held stable while out_valid && !out_ready (AXI-stream rules). in_conj and in_tag are sampled only on an input transfer.
- The S1 datapath may load garbage when in_valid=0. Only valid qualifies the data.
- The -32768 twiddle is legal and must not overflow the W-bit sums.

Decomposition:
- Package fft_pkg holds:
  - typedef cmul_cfg_t (shift, out width)
  - function sat_round(sum, SHIFT, OUT_WIDTH)
  - localparam CMUL_LATENCY=3
- Sub-module cmul_round_sat: combinational round plus saturate for one component, instantiated twice in S3.
- The stage registers and handshake stay in the top module.

Test Plan:
1. Defaults, out_ready=1: a=(1000,-500), b=(16384,0), conj=0, tag=0x5A → 3 clk later c=(500,-250), out_tag=0x5A, out_sat=0.
2. Rounding: a=(3,0), b=(16384,0) → c_r=2. Then a=(-3,0), same b → c_r=-1 (half rounds up).
3. Conjugate: a=(0,1000), b=(0,32767); conj=1 → c=(1000,0). conj=0 → c=(-1000,0).
4. Saturation with OUT_WIDTH=21: a=(-2^20, 2^20-1), b=(-32768,-32768) → c_r=1048575, c_i=1, out_sat=1, sat_sticky=1 afterward.
5. Backpressure: stream 10 tagged samples, toggle out_ready pseudo-randomly → in_ready mirrors adv, all 10 results arrive in order, unchanged while stalled, no loss or duplication.
6. Reset mid-flight: load 3 samples, assert rst for 1 clk → out_valid=0 next cycle, none of the 3 ever emerges, sat_sticky=0.
